// File: rtl/spi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spi_pkg
// Brief    : Shared constants and state type for the SPI master/slave pair.
// Revision : 1.0
// ----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DW   = 32;
    localparam int SPI_SYNC = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_slv_st_t;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spi_slave_if
// Brief    : SPI pins plus parallel word side of the in-fabric SPI slave.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int DW = SPI_DW
);

    logic          cs;
    logic          sck;
    logic          mosi;
    logic          miso;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          busy;
    logic          frame_err;

    modport slave (
        input  cs, sck, mosi, din,
        output miso, dout, dout_vld, busy, frame_err
    );

    modport master (
        output cs, sck, mosi, din,
        input  miso, dout, dout_vld, busy, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spi_sync_edge
// Brief    : N-flop synchronizer with rise/fall detection for one input bit.
// Revision : 1.0
// ----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   SYNC    = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_lvl,
    output logic      o_rise,
    output logic      o_fall
);

    logic [SYNC-1:0] r_sync;
    logic            r_prev;

    // Reset to the pin's idle level so no edge is reported as reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], i_d};
            r_prev <= r_sync[SYNC-1];
        end
    end

    assign o_lvl  = r_sync[SYNC-1];
    assign o_rise = r_sync[SYNC-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spi_slave
// Brief    : Mode-0, MSB-first SPI slave, oversampled on clk, back-to-back words.
// Revision : 1.0
// ----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int DW   = SPI_DW,
    parameter int SYNC = SPI_SYNC
) (
    input wire logic   clk,
    input wire logic   rst,
    spi_slave_if.slave bus
);

    localparam int               c_cw   = $clog2(DW);
    localparam logic [c_cw-1:0] c_last = c_cw'(DW - 1);

    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_sck_lvl, w_sck_rise_raw, w_sck_fall_raw;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_sck_rise, w_sck_fall;
    logic w_unused;

    spi_slv_st_t     r_state;
    logic [c_cw-1:0] r_bitcnt;
    logic [c_cw-1:0] w_bitcnt_nxt;
    logic [DW-1:0]   r_txsr;
    logic [DW-2:0]   r_rxsr;
    logic [DW-1:0]   r_dout;
    logic            r_dout_vld;
    logic            r_frame_err;

    spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.cs),
        .o_lvl  (w_cs_lvl),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_sck (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.sck),
        .o_lvl  (w_sck_lvl),
        .o_rise (w_sck_rise_raw),
        .o_fall (w_sck_fall_raw)
    );

    spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.mosi),
        .o_lvl  (w_mosi),
        .o_rise (w_mosi_rise),
        .o_fall (w_mosi_fall)
    );

    assign w_unused   = ^{w_sck_lvl, w_mosi_rise, w_mosi_fall};
    assign w_sck_rise = w_sck_rise_raw & ~w_cs_lvl;
    assign w_sck_fall = w_sck_fall_raw & ~w_cs_lvl;

    generate
        if ((1 << c_cw) == DW) begin : g_wrap_nat
            assign w_bitcnt_nxt = r_bitcnt + 1'b1;
        end else begin : g_wrap_cmp
            assign w_bitcnt_nxt = (r_bitcnt == c_last) ? '0 : r_bitcnt + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_txsr      <= '0;
            r_rxsr      <= '0;
            r_dout      <= '0;
            r_dout_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_dout_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state  <= SHIFT;
                        r_txsr   <= bus.din;
                        r_bitcnt <= '0;
                        r_rxsr   <= '0;
                    end
                end
                SHIFT: begin
                    // A cs edge takes priority over any sck edge in the same clk.
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_bitcnt    <= '0;
                        r_frame_err <= (r_bitcnt != '0);
                    end else if (w_sck_rise) begin
                        r_rxsr   <= {r_rxsr[DW-3:0], w_mosi};
                        r_bitcnt <= w_bitcnt_nxt;
                        if (r_bitcnt == c_last) begin
                            r_dout     <= {r_rxsr, w_mosi};
                            r_dout_vld <= 1'b1;
                        end
                    end else if (w_sck_fall) begin
                        // Word boundary reloads so the next MSB leads the next rise.
                        r_txsr <= (r_bitcnt != '0) ? (r_txsr << 1) : bus.din;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.miso      = (r_state == SHIFT) & r_txsr[DW-1];
    assign bus.dout      = r_dout;
    assign bus.dout_vld  = r_dout_vld;
    assign bus.busy      = (r_state == SHIFT);
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire
